// File: rtl/mem_write_checker_if.sv
// Bundle of the table-load, control, core write-port and verdict signals of mem_write_checker.
// master drives loads/control/writes (bench or SoC glue); slave is the checker itself.
interface mem_write_checker_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic              ld_en;
    logic [IW-1:0]     ld_idx;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [CW-1:0]     cfg_count;
    logic              cfg_ordered;
    logic              start;
    logic              clear;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              done;
    logic              pass;
    logic              fail;
    logic [1:0]        fail_code;
    logic [IW-1:0]     fail_idx;
    logic [CW-1:0]     match_cnt;
    logic [TW-1:0]     cycles;

    modport master (
        output ld_en, ld_idx, ld_addr, ld_data, cfg_count, cfg_ordered, start, clear,
               memwrite, dataadr, writedata,
        input  done, pass, fail, fail_code, fail_idx, match_cnt, cycles
    );

    modport slave (
        input  ld_en, ld_idx, ld_addr, ld_data, cfg_count, cfg_ordered, start, clear,
               memwrite, dataadr, writedata,
        output done, pass, fail, fail_code, fail_idx, match_cnt, cycles
    );
endinterface

// File: rtl/mem_write_checker.sv
// Bring-up self-check: compares core data-memory writes against a loaded table of expected
// (address, data) pairs, in order or any order, with an exempt address window and a timeout.
module mem_write_checker_entry #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              hit
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
            data <= '0;
        end else if (we) begin
            addr <= ld_addr;
            data <= ld_data;
        end
    end

    assign hit = (addr == dataadr) && (data == writedata);
endmodule

module mem_write_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int IGN_LO  = 80,
    parameter int IGN_HI  = 80
) (
    input logic                clk,
    input logic                reset,
    mem_write_checker_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0]     CMAX  = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] LO    = ADDR_W'(IGN_LO);
    localparam logic [ADDR_W-1:0] HI    = ADDR_W'(IGN_HI);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t        state;
    logic [DEPTH-1:0] hit, valid, bitmap, avail, pick, ld_we;
    logic [CW-1:0] cnt_lat, match_cnt, mc_nxt;
    logic          ord_lat;
    logic [TW-1:0] cycles, cyc_nxt;
    logic [1:0]    fail_code, bad_code;
    logic [IW-1:0] fail_idx;
    logic          done_q, pass_q, fail_q;
    logic          act, ok, bad;

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_ent
        assign ld_we[g] = bus.ld_en && (state == S_IDLE) && (bus.ld_idx == IW'(g));
        mem_write_checker_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ent (
            .clk       (clk),
            .reset     (reset),
            .we        (ld_we[g]),
            .ld_addr   (bus.ld_addr),
            .ld_data   (bus.ld_data),
            .dataadr   (bus.dataadr),
            .writedata (bus.writedata),
            .hit       (hit[g])
        );
    end

    // Exempt writes never reach the compare, even if they equal a table entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) valid[i] = (CW'(i) < cnt_lat);
        avail    = hit & valid & ~bitmap;
        pick     = avail & (~avail + DEPTH'(1));
        act      = bus.memwrite && !((bus.dataadr >= LO) && (bus.dataadr <= HI)) && (cnt_lat != '0);
        ok       = 1'b0;
        bad      = 1'b0;
        bad_code = 2'd1;
        if (act) begin
            if (ord_lat) begin
                ok = hit[match_cnt[IW-1:0]];
            end else begin
                ok = |avail;
                if (!ok && |(hit & valid)) bad_code = 2'd3;
            end
            bad = !ok;
        end
        mc_nxt  = match_cnt + CW'(ok);
        cyc_nxt = (cycles == TLAST) ? cycles : cycles + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bitmap    <= '0;
            cnt_lat   <= '0;
            ord_lat   <= 1'b0;
            match_cnt <= '0;
            cycles    <= '0;
            fail_code <= 2'd0;
            fail_idx  <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else if (bus.clear) begin
            state     <= S_IDLE;
            bitmap    <= '0;
            match_cnt <= '0;
            cycles    <= '0;
            fail_code <= 2'd0;
            fail_idx  <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    cnt_lat   <= (bus.cfg_count > CMAX) ? CMAX : bus.cfg_count;
                    ord_lat   <= bus.cfg_ordered;
                    bitmap    <= '0;
                    match_cnt <= '0;
                    cycles    <= '0;
                    fail_code <= 2'd0;
                    fail_idx  <= '0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    cycles    <= cyc_nxt;
                    match_cnt <= mc_nxt;
                    if (ok && !ord_lat) bitmap <= bitmap | pick;
                    // Completion beats both a same-edge mismatch and the timeout.
                    if (mc_nxt == cnt_lat) begin
                        state  <= S_PASS;
                        done_q <= 1'b1;
                        pass_q <= 1'b1;
                    end else if (bad || cycles == TLAST) begin
                        state     <= S_FAIL;
                        done_q    <= 1'b1;
                        fail_q    <= 1'b1;
                        fail_code <= bad ? bad_code : 2'd2;
                        fail_idx  <= ord_lat ? match_cnt[IW-1:0] : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.fail_code = fail_code;
    assign bus.fail_idx  = fail_idx;
    assign bus.match_cnt = match_cnt;
    assign bus.cycles    = cycles;
endmodule
